// File: rtl/ddr3_rx_align_pkg.sv
// Shared types and constants for the DDR3 read-side DQ alignment block.
package ddr3_rx_align_pkg;

    localparam int GEAR_WIDTH  = 4;
    localparam int BURST_WORDS = 2;

    typedef logic [GEAR_WIDTH-1:0] dq_word_t;

    // DDR3 MPR readout is an alternating 0/1 stream; bit0 is the earliest UI.
    localparam dq_word_t MPR_PATTERN = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        DONE,
        FAIL
    } train_state_t;

endpackage

// File: rtl/ddr3_rx_dq_align_if.sv
// Controller-facing bundle of the DQ alignment block; MPR_MODE/ERR_CNT exist only
// when DDR3_RX_ALIGN_ERR_CNT_EN is defined.
interface ddr3_rx_dq_align_if;
    import ddr3_rx_align_pkg::*;

    logic       train_start;
    dq_word_t   rx_data_0;
    logic       rd_cmd;
    logic       rx_bit_slip_0;
    logic       train_busy;
    logic       train_done;
    logic       train_fail;
    logic [2:0] slip_cnt;
    dq_word_t   rd_data;
    logic       rd_valid;
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
    logic        mpr_mode;
    logic [15:0] err_cnt;

    modport master (
        output train_start, rx_data_0, rd_cmd, mpr_mode,
        input  rx_bit_slip_0, train_busy, train_done, train_fail, slip_cnt,
               rd_data, rd_valid, err_cnt
    );
    modport slave (
        input  train_start, rx_data_0, rd_cmd, mpr_mode,
        output rx_bit_slip_0, train_busy, train_done, train_fail, slip_cnt,
               rd_data, rd_valid, err_cnt
    );
`else
    modport master (
        output train_start, rx_data_0, rd_cmd,
        input  rx_bit_slip_0, train_busy, train_done, train_fail, slip_cnt,
               rd_data, rd_valid
    );
    modport slave (
        input  train_start, rx_data_0, rd_cmd,
        output rx_bit_slip_0, train_busy, train_done, train_fail, slip_cnt,
               rd_data, rd_valid
    );
`endif

endinterface

// File: rtl/ddr3_rd_valid_pipe.sv
// ddr3_rd_valid_pipe: read-command delay line; valid is the OR of BURST_WORDS taps.
// Latency: valid in cycles RD_LATENCY .. RD_LATENCY+BURST_WORDS-1 after the command.
// Backpressure: none; overlapping commands simply merge their valid windows.
module ddr3_rd_valid_pipe #(
    parameter int RD_LATENCY  = 12,
    parameter int BURST_WORDS = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rd_cmd,
    output logic o_rd_valid
);

    localparam int DEPTH = RD_LATENCY - 1 + BURST_WORDS;

    // r_sr[k] holds the command issued k+1 cycles ago.
    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[DEPTH-2:0], i_rd_cmd};
        end
    end

    assign o_rd_valid = |r_sr[DEPTH-1 -: BURST_WORDS];

endmodule

// File: rtl/ddr3_rx_dq_align.sv
// ddr3_rx_dq_align: MPR bit-slip read training and read-valid generation for one DQ lane.
// Latency: RX_DATA_0 -> RD_DATA 1 cycle; RD_CMD -> RD_VALID RD_LATENCY cycles, BURST_WORDS long.
// Backpressure: none; RD_VALID masked while training. DDR3_RX_ALIGN_ERR_CNT_EN adds MPR_MODE/ERR_CNT.
module ddr3_rx_dq_align
    import ddr3_rx_align_pkg::*;
#(
    parameter dq_word_t TRAIN_PATTERN = MPR_PATTERN,
    parameter int       SETTLE_CYCLES = 4,
    parameter int       MATCH_COUNT   = 8,
    parameter int       MAX_SLIPS     = 4,
    parameter int       RD_LATENCY    = 12
) (
    input logic               i_fab_clk,
    input logic               i_arst,
    ddr3_rx_dq_align_if.slave rx_if
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [2:0] SLIP_LIMIT  = 3'(MAX_SLIPS);

    train_state_t r_state;
    dq_word_t     r_rx_word;
    logic [3:0]   r_settle_cnt;
    logic [7:0]   r_match_cnt;
    logic [2:0]   r_slip_cnt;
    logic         r_busy;
    logic         r_done;
    logic         r_fail;
    logic         r_slip;
    logic         w_pipe_valid;
    logic         w_rd_valid;
    logic         w_word_match;
    logic         w_start;

    always_ff @(posedge i_fab_clk or posedge i_arst) begin
        if (i_arst) begin
            r_rx_word <= '0;
        end else begin
            r_rx_word <= rx_if.rx_data_0;
        end
    end

    assign w_word_match = (r_rx_word == TRAIN_PATTERN);
    assign w_start      = (r_state == IDLE) && rx_if.train_start;

    // Outputs are set on entry to the state they belong to, so the slip pulse
    // coincides exactly with SLIP and DONE/FAIL flags appear with their state.
    always_ff @(posedge i_fab_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_slip_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_slip       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_if.train_start) begin
                        r_state      <= SETTLE;
                        r_busy       <= 1'b1;
                        r_settle_cnt <= '0;
                        r_match_cnt  <= '0;
                        r_slip_cnt   <= '0;
                        r_done       <= 1'b0;
                        r_fail       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (w_word_match) begin
                        r_match_cnt <= r_match_cnt + 8'd1;
                        if (r_match_cnt == MATCH_LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_match_cnt <= '0;
                        if (r_slip_cnt == SLIP_LIMIT) begin
                            r_state <= FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state <= SLIP;
                            r_slip  <= 1'b1;
                        end
                    end
                end
                SLIP: begin
                    r_slip     <= 1'b0;
                    r_slip_cnt <= r_slip_cnt + 3'd1;
                    r_state    <= SETTLE;
                end
                DONE, FAIL: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_slip  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ddr3_rd_valid_pipe #(
        .RD_LATENCY  (RD_LATENCY),
        .BURST_WORDS (BURST_WORDS)
    ) u_rd_valid_pipe (
        .i_clk      (i_fab_clk),
        .i_rst      (i_arst),
        .i_rd_cmd   (rx_if.rd_cmd),
        .o_rd_valid (w_pipe_valid)
    );

    // Commands issued during training still age through the pipe; only the output is gated.
    assign w_rd_valid = w_pipe_valid & ~r_busy;

    assign rx_if.rx_bit_slip_0 = r_slip;
    assign rx_if.train_busy    = r_busy;
    assign rx_if.train_done    = r_done;
    assign rx_if.train_fail    = r_fail;
    assign rx_if.slip_cnt      = r_slip_cnt;
    assign rx_if.rd_data       = r_rx_word;
    assign rx_if.rd_valid      = w_rd_valid;

`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_event;

    // CHECK implies busy, which masks RD_VALID, so the two sources never coincide.
    assign w_err_event = ~w_word_match &
                         ((r_state == CHECK) | (w_rd_valid & rx_if.mpr_mode));

    always_ff @(posedge i_fab_clk or posedge i_arst) begin
        if (i_arst) begin
            r_err_cnt <= '0;
        end else if (w_start) begin
            r_err_cnt <= '0;
        end else if (w_err_event && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign rx_if.err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ddr3_rx_dq_align.sv
// Bench for ddr3_rx_dq_align: directed training scenarios plus a randomized
// read-valid/data phase checked against a cycle-indexed command history.
`timescale 1ns/1ps
module tb_ddr3_rx_dq_align;

    localparam int             S       = 4;
    localparam int             M       = 8;
    localparam int             MAXS    = 4;
    localparam int             RL      = 12;
    localparam int             NR      = 300;
    localparam logic [3:0]     PAT     = 4'hA;
    localparam logic [3:0]     ROT_PAT = 4'h1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ddr3_rx_dq_align_if ifa ();
    ddr3_rx_dq_align_if ifb ();

    ddr3_rx_dq_align u_dut (
        .i_fab_clk (clk),
        .i_arst    (rst),
        .rx_if     (ifa)
    );

    // 4'hA maps onto itself after two rotations, so the slip-search case uses
    // an asymmetric pattern where every rotation is distinct.
    ddr3_rx_dq_align #(.TRAIN_PATTERN(ROT_PAT)) u_dut_rot (
        .i_fab_clk (clk),
        .i_arst    (rst),
        .rx_if     (ifb)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
        logic [7:0] d;
        d = {w, w} << n;
        return d[7:4];
    endfunction

    // IOD model for the second lane: each slip moves the word one rotation closer.
    int rot_off = 3;
    int slip_q[$];
    always @(negedge clk) begin
        if (ifb.rx_bit_slip_0 === 1'b1) begin
            slip_q.push_back(cyc);
            rot_off = (rot_off + 3) % 4;
        end
        ifb.rx_data_0 = rotl(ROT_PAT, rot_off);
    end

    int          c0, d1, d2, b1, ns, fcyc, bcyc, slip_a;
    bit          ev;
    bit          cmd_a [NR];
    logic [3:0]  rx_a  [NR];
    bit          mpr_a;
    logic [15:0] exp_err;

    initial begin
        ifa.train_start = 1'b0;
        ifa.rx_data_0   = 4'h0;
        ifa.rd_cmd      = 1'b0;
        ifb.train_start = 1'b0;
        ifb.rd_cmd      = 1'b0;
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        ifa.mpr_mode = 1'b0;
        ifb.mpr_mode = 1'b0;
`endif
        exp_err = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",     ifa.train_busy,    0);
        chk("rst_done",     ifa.train_done,    0);
        chk("rst_fail",     ifa.train_fail,    0);
        chk("rst_slip",     ifa.rx_bit_slip_0, 0);
        chk("rst_slip_cnt", ifa.slip_cnt,      0);
        chk("rst_rd_valid", ifa.rd_valid,      0);
        chk("rst_rd_data",  ifa.rd_data,       0);
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        chk("rst_err_cnt",  ifa.err_cnt,       0);
`endif
        rst = 1'b0;
        ifa.rx_data_0 = PAT;
        repeat (4) @(negedge clk);

        // Pre-aligned lane and 3-slips-off lane trained together.
        c0 = cyc; d1 = -1; d2 = -1; b1 = -1; slip_a = 0;
        ifa.train_start = 1'b1;
        ifb.train_start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            ifa.train_start = (k == 3);
            ifb.train_start = 1'b0;
            ifa.rd_cmd      = (k == 1);
            if (ifa.rx_bit_slip_0) slip_a++;
            if (ifa.train_done && d1 < 0) d1 = k;
            if (!ifa.train_busy && b1 < 0) b1 = k;
            if (ifb.train_done && d2 < 0) d2 = k;
            if (k >= 12 && k <= 15) chk("busy_mask_valid", ifa.rd_valid, (k == 14));
        end
        chk("t1_done_cycle", d1, S + M + 1);
        chk("t1_busy_fall",  b1, S + M + 2);
        chk("t1_no_slips",   slip_a, 0);
        chk("t1_slip_cnt",   ifa.slip_cnt, 0);
        chk("t1_done",       ifa.train_done, 1);
        chk("t2_num_slips",  slip_q.size(), 3);
        for (int j = 0; j < slip_q.size() && j < 3; j++)
            chk("t2_slip_cycle", slip_q[j] - c0, (S + 2) * (j + 1));
        chk("t2_done_cycle", d2, 3 * (S + 2) + S + M + 1);
        chk("t2_slip_cnt",   ifb.slip_cnt, 3);
        chk("t2_done",       ifb.train_done, 1);
        chk("t2_fail",       ifb.train_fail, 0);
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        chk("t2_err_cnt",    ifb.err_cnt, 3);
`endif

        // Read pipe: back-to-back at spacing 2 first, then random traffic.
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            if (i > 0) chk("rd_data", ifa.rd_data, rx_a[i-1]);
            ev = (i >= RL && cmd_a[i-RL]) || (i >= RL + 1 && cmd_a[i-RL-1]);
            chk((i < 20) ? "rd_valid_b2b" : "rd_valid", ifa.rd_valid, ev);
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
            chk("err_cnt_post", ifa.err_cnt, exp_err);
`endif
            if (i < 20) cmd_a[i] = (i == 0 || i == 2);
            else        cmd_a[i] = ($urandom_range(0, 3) == 0);
            rx_a[i] = (i % 3 == 0) ? PAT : 4'($urandom);
            ifa.rd_cmd    = cmd_a[i];
            ifa.rx_data_0 = rx_a[i];
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
            mpr_a = 1'($urandom_range(0, 1));
            ifa.mpr_mode = mpr_a;
            if (ev && mpr_a && rx_a[i-1] != PAT) exp_err++;
`endif
        end
        ifa.rd_cmd = 1'b0;
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        ifa.mpr_mode = 1'b0;
`endif
        repeat (RL + 3) @(negedge clk);

        // Input stuck low: every slip attempted, then failure.
        ifa.rx_data_0 = 4'h0;
        repeat (2) @(negedge clk);
        ns = 0; fcyc = -1; bcyc = -1;
        ifa.train_start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            ifa.train_start = 1'b0;
            if (ifa.rx_bit_slip_0) begin
                if (ns < MAXS) chk("t3_slip_cycle", k, (S + 2) * (ns + 1));
                ns++;
            end
            if (ifa.train_fail && fcyc < 0) fcyc = k;
            if (!ifa.train_busy && bcyc < 0) bcyc = k;
        end
        chk("t3_num_slips",  ns, MAXS);
        chk("t3_fail_cycle", fcyc, (S + 2) * MAXS + S + 2);
        chk("t3_busy_fall",  bcyc, (S + 2) * MAXS + S + 3);
        chk("t3_fail",       ifa.train_fail, 1);
        chk("t3_done",       ifa.train_done, 0);
        chk("t3_slip_cnt",   ifa.slip_cnt, MAXS);
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        chk("t3_err_cnt",    ifa.err_cnt, MAXS + 1);
`endif

        // Reset while the second slip pulse is high, then a clean retrain.
        ns = 0;
        ifa.train_start = 1'b1;
        for (int k = 0; k < 60 && ns < 2; k++) begin
            @(negedge clk);
            ifa.train_start = 1'b0;
            if (ifa.rx_bit_slip_0) ns++;
        end
        chk("t5_slip_seen", ns, 2);
        rst = 1'b1;
        #1;
        chk("t5_arst_slip",     ifa.rx_bit_slip_0, 0);
        chk("t5_arst_busy",     ifa.train_busy, 0);
        chk("t5_arst_slip_cnt", ifa.slip_cnt, 0);
        chk("t5_arst_done",     ifa.train_done, 0);
        chk("t5_arst_fail",     ifa.train_fail, 0);
`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        chk("t5_arst_err_cnt",  ifa.err_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        ifa.rx_data_0 = PAT;
        repeat (2) @(negedge clk);
        d1 = -1; slip_a = 0;
        ifa.train_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ifa.train_start = 1'b0;
            if (ifa.rx_bit_slip_0) slip_a++;
            if (ifa.train_done && d1 < 0) d1 = k;
        end
        chk("t5_done_cycle", d1, S + M + 1);
        chk("t5_no_slips",   slip_a, 0);
        chk("t5_slip_cnt",   ifa.slip_cnt, 0);
        chk("t5_fail",       ifa.train_fail, 0);

`ifdef DDR3_RX_ALIGN_ERR_CNT_EN
        // Continuous valid non-pattern words in MPR mode drive the counter to saturation.
        ifa.mpr_mode  = 1'b1;
        ifa.rx_data_0 = 4'h5;
        ifa.rd_cmd    = 1'b1;
        repeat (1000) @(negedge clk);
        chk("err_cnt_mid", ifa.err_cnt, 1000 - RL);
        repeat (69000) @(negedge clk);
        chk("err_cnt_sat", ifa.err_cnt, 16'hFFFF);
        ifa.rd_cmd    = 1'b0;
        ifa.mpr_mode  = 1'b0;
        ifa.rx_data_0 = PAT;
        ifa.train_start = 1'b1;
        @(negedge clk);
        ifa.train_start = 1'b0;
        chk("err_cnt_start_clr", ifa.err_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr3_rx_dq_align.md
Name: ddr3_rx_dq_align

Overview:
- Read-side counterpart to the PHY's output IOD lanes.
- Consumes the 4-bit per-FAB_CLK deserialized word from one DQ input IOD.
- Runs bit-slip read training against the DDR3 MPR pattern: pulses the IOD bit-slip until the word matches, then reports done or fail.
- After training, generates read-data-valid from issued read commands using a fixed latency pipe, and forwards aligned data to the controller.

Parameters:
- TRAIN_PATTERN, 4'hA, expected aligned word; bit0 is the earliest UI.
- SETTLE_CYCLES, 4, wait after each slip before comparing (IOD slip latency), range 1..15.
- MATCH_COUNT, 8, consecutive matching words required to declare alignment, range 1..255.
- MAX_SLIPS, 4, slips attempted before failing (4 = one full rotation at 4:1 gearing).
- RD_LATENCY, 12, FAB_CLK cycles from RD_CMD to first valid data word, range 2..31.

Ports:
- FAB_CLK in 1: fabric clock, sole clock domain.
- ARST in 1: asynchronous, active-high reset.
- TRAIN_START in 1: single-cycle pulse; begins training (MPR mode already enabled by controller).
- RX_DATA_0 in 4: deserialized DQ word from the IOD.
- RD_CMD in 1: pulse marking a read burst (BL8) issued to DRAM.
- RX_BIT_SLIP_0 out 1: one-cycle slip request to the IOD.
- TRAIN_BUSY out 1: high in any training state.
- TRAIN_DONE out 1: sticky alignment success.
- TRAIN_FAIL out 1: sticky alignment failure.
- SLIP_CNT out 3: slips issued in the last training run.
- RD_DATA out 4: RX_DATA_0 registered once.
- RD_VALID out 1: qualifies RD_DATA.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; latency pipe cleared.
- Input register: RX_DATA_0 is registered once. All compares and RD_DATA use the registered word (1-cycle latency).
- FSM states:
  - IDLE: on TRAIN_START -> SETTLE. Clear SLIP_CNT, match counter, TRAIN_DONE and TRAIN_FAIL.
  - SETTLE: count SETTLE_CYCLES, then -> CHECK.
  - CHECK: each cycle, compare the registered word to TRAIN_PATTERN.
    - Match: increment the match counter. When it reaches MATCH_COUNT -> DONE.
    - Mismatch: clear the match counter. If SLIP_CNT == MAX_SLIPS -> FAIL, otherwise -> SLIP.
  - SLIP: assert RX_BIT_SLIP_0 for exactly one cycle, increment SLIP_CNT, -> SETTLE.
  - DONE: TRAIN_DONE=1 -> IDLE.
  - FAIL: TRAIN_FAIL=1 -> IDLE.
- TRAIN_DONE and TRAIN_FAIL stay asserted until the next TRAIN_START or ARST.
- TRAIN_START while busy is ignored. No restart mid-run.
- Aligned first time: SLIP_CNT=0; DONE is reached SETTLE_CYCLES+MATCH_COUNT cycles after start.
- Latency pipe: RD_CMD enters a RD_LATENCY+1 deep shift register. RD_VALID is high in cycles RD_LATENCY and RD_LATENCY+1 after RD_CMD (BL8 = 2 words at 4:1 gearing).
- Back-to-back RD_CMD at 2-cycle spacing yields continuous RD_VALID.
- RD_CMD on consecutive cycles: valid windows merge (OR of taps). No error is raised; the controller must not issue at that spacing.
- RD_VALID is forced 0 while TRAIN_BUSY. Commands issued during training still shift through the pipe but are masked.
- ARST mid-training: immediate return to IDLE. RX_BIT_SLIP_0 deasserts asynchronously, so no partial slip pulse can follow.

Optional Feature:
- Macro: DDR3_RX_ALIGN_ERR_CNT_EN.
- Defined: adds output ERR_CNT (16 bit). It counts CHECK-state mismatches plus post-training words with RD_VALID=1 that differ from TRAIN_PATTERN while MPR mode is indicated by the extra input MPR_MODE.
  - ERR_CNT saturates at 16'hFFFF.
  - ERR_CNT clears on TRAIN_START and ARST.
- Undefined: no ERR_CNT and no MPR_MODE port; no counter logic.

Decomposition:
- Package ddr3_rx_align_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, SLIP, DONE, FAIL);
  - GEAR_WIDTH=4;
  - BURST_WORDS=2;
  - default MPR pattern constant 4'hA.
- Sub-module ddr3_rd_valid_pipe implements the RD_CMD shift register and the valid tap OR, parameterized by RD_LATENCY and BURST_WORDS.

Test Plan:
- Pre-aligned input 4'hA constant, TRAIN_START -> no slip pulses, SLIP_CNT=0, TRAIN_DONE at cycle 13 after start (1+4+8).
- Input model that rotates the word by one bit per slip, starting 3 slips off -> exactly 3 single-cycle RX_BIT_SLIP_0 pulses separated by at least 5 cycles, SLIP_CNT=3, TRAIN_DONE=1.
- Input stuck at 4'h0 -> 4 slips then TRAIN_FAIL=1, TRAIN_DONE=0, TRAIN_BUSY drops.
- After DONE, RD_CMD at cycle 0 and cycle 2 -> RD_VALID high cycles 12–15 continuously, RD_DATA equals RX_DATA_0 delayed by 1.
- ARST asserted during SLIP -> RX_BIT_SLIP_0 and all flags 0 immediately; new TRAIN_START retrains cleanly.
- With DDR3_RX_ALIGN_ERR_CNT_EN, 5 mismatches injected during CHECK -> ERR_CNT=5; 70000 mismatches -> ERR_CNT=16'hFFFF.
